alu_seq_ctrl: RTL and testbench

Multi-cycle ALU sequencer that accepts one operation at a time over a start/busy/done handshake. It latches the operands and runs single-cycle logic/arithmetic ops or iterative shift and multiply ops. It then returns a registered 32-bit result with a zero flag equal to the NOR-reduction of the result. It sits between the CPU control unit and the ALU datapath and owns the sequencing of every op that takes more than one cycle.

---
 rtl/alu_seq_ctrl_if.sv | 23 ++
 rtl/alu_seq_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Request/response bundle between the CPU control unit and the ALU sequencer.
// The control unit drives the master side; the sequencer implements the slave side.
interface alu_seq_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] res;
  logic        zero;
  logic        overflow;

  modport master (
    output start, op, A, B,
    input  busy, done, res, zero, overflow
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, res, zero, overflow
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: single-cycle logic/arith ops plus iterative
// shift (1 bit/cycle) and shift-add multiply, with a start/busy/done handshake.
module alu_seq_ctrl (
  input  logic          clk,
  input  logic          rst,
  alu_seq_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [1:0]  state;
  logic [5:0]  cnt;
  logic [2:0]  op_q;
  // wa: operand A, shift working register, or MUL multiplicand
  // wb: operand B, or MUL multiplier
  logic [31:0] wa;
  logic [31:0] wb;
  logic [31:0] acc;
  logic [31:0] res_q;
  logic        zero_q;
  logic        ovf_q;

  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] alu_val;
  logic [31:0] sh_next;
  logic [31:0] acc_next;
  logic [31:0] fin_val;
  logic        fin_ovf;
  logic        finish;
  logic        ovf_add;
  logic        ovf_sub;
  logic        slt;
  logic [5:0]  cnt_load;

  always_comb begin
    sum      = wa + wb;
    diff     = wa - wb;
    slt      = $signed(wa) < $signed(wb);
    ovf_add  = (wa[31] == wb[31]) && (sum[31] != wa[31]);
    ovf_sub  = (wa[31] != wb[31]) && (diff[31] != wa[31]);
    sh_next  = (op_q == OP_SLL) ? (wa << 1) : (wa >> 1);
    acc_next = acc + (wb[0] ? wa : '0);

    alu_val = '0;
    case (op_q)
      OP_AND:  alu_val = wa & wb;
      OP_OR:   alu_val = wa | wb;
      OP_ADD:  alu_val = sum;
      OP_SUB:  alu_val = diff;
      OP_SLT:  alu_val = {31'b0, slt};
      default: alu_val = '0;
    endcase

    // Single-cycle ops load cnt=1, so they finish on the first EXEC cycle;
    // a shift loaded with 0 also finishes immediately and returns A untouched.
    finish = (cnt <= 6'd1);

    fin_val = alu_val;
    fin_ovf = 1'b0;
    case (op_q)
      OP_SLL, OP_SRL: fin_val = (cnt == 6'd0) ? wa : sh_next;
      OP_MUL:         fin_val = acc_next;
      OP_ADD:         fin_ovf = ovf_add;
      OP_SUB:         fin_ovf = ovf_sub;
      default:        fin_ovf = 1'b0;
    endcase
  end

  always_comb begin
    cnt_load = 6'd1;
    case (bus.op)
      OP_MUL:         cnt_load = 6'd32;
      OP_SLL, OP_SRL: cnt_load = {1'b0, bus.B[4:0]};
      default:        cnt_load = 6'd1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      wa     <= '0;
      wb     <= '0;
      acc    <= '0;
      res_q  <= '0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            op_q  <= bus.op;
            wa    <= bus.A;
            wb    <= bus.B;
            acc   <= '0;
            cnt   <= cnt_load;
            state <= S_EXEC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_EXEC: begin
          if (finish) begin
            res_q  <= fin_val;
            zero_q <= ~|fin_val;
            ovf_q  <= fin_ovf;
            cnt    <= '0;
            state  <= S_DONE;
          end else begin
            cnt <= cnt - 6'd1;
            if (op_q == OP_MUL) begin
              acc <= acc_next;
              wa  <= wa << 1;
              wb  <= wb >> 1;
            end else begin
              wa <= sh_next;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == S_EXEC);
  assign bus.done     = (state == S_DONE);
  assign bus.res      = res_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed and random checks of alu_seq_ctrl against an arithmetic reference model.
module tb_alu_seq_ctrl;

  logic clk;
  logic rst;
  int   n_asrt;
  int   n_fail;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa;
    longint          sb;
    logic [63:0]     prod;
    logic [4:0]      sh;
    sa   = $signed(a);
    sb   = $signed(b);
    sh   = b[4:0];
    prod = {32'b0, a} * {32'b0, b};
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return (sa < sb) ? 32'd1 : 32'd0;
      3'b011:  return a << sh;
      3'b100:  return a >> sh;
      default: return prod[31:0];
    endcase
  endfunction

  function automatic logic ref_ovf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint s;
    sa = $signed(a);
    sb = $signed(b);
    if (op == 3'b010)      s = sa + sb;
    else if (op == 3'b110) s = sa - sb;
    else                   return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if (op == 3'b101) return 32;
    if (op == 3'b011 || op == 3'b100) return (sh > 1) ? sh : 1;
    return 1;
  endfunction

  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
  endtask

  task automatic scramble_inputs();
    bus.start = 1'($urandom);
    bus.op    = 3'($urandom);
    bus.A     = $urandom;
    bus.B     = $urandom;
  endtask

  // Called right at the accept edge; returns #1 after the edge that raised done.
  task automatic finish_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit scramble);
    int          n;
    bit          seen;
    logic [31:0] exp_res;
    exp_res = ref_res(op, a, b);
    #1;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    check("done_low_after_accept", 32'(bus.done), 32'd0);
    if (scramble) scramble_inputs();
    else bus.start = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) seen = 1'b1;
      else if (scramble) scramble_inputs();
    end
    bus.start = 1'b0;
    check("done_seen", 32'(seen), 32'd1);
    check("latency", 32'(n), 32'(ref_lat(op, b)));
    check("busy_in_done", 32'(bus.busy), 32'd0);
    check("res", bus.res, exp_res);
    check("zero", 32'(bus.zero), (exp_res == 32'd0) ? 32'd1 : 32'd0);
    check("overflow", 32'(bus.overflow), 32'(ref_ovf(op, a, b)));
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit scramble);
    @(negedge clk);
    launch(op, a, b);
    @(posedge clk);
    finish_op(op, a, b, scramble);
  endtask

  task automatic expect_idle(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    n_asrt    = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.A     = '0;
    bus.B     = '0;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_res", bus.res, 32'd0);
    check("rst_zero", 32'(bus.zero), 32'd1);
    check("rst_ovf", 32'(bus.overflow), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    repeat (3) expect_idle("no_start");

    // Zero flag via SUB, then signed overflow via ADD
    do_op(3'b110, 32'h0000_1234, 32'h0000_1234, 1'b0);
    check("sub_res_zero", bus.res, 32'd0);
    expect_idle("pulse_end");
    do_op(3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    check("add_res_8000", bus.res, 32'h8000_0000);
    check("add_ovf_set", 32'(bus.overflow), 32'd1);
    do_op(3'b110, 32'h8000_0000, 32'h0000_0001, 1'b0);
    do_op(3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    do_op(3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    do_op(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0);
    do_op(3'b001, 32'hF000_0000, 32'h0000_000F, 1'b0);

    // Shift boundaries
    do_op(3'b011, 32'h0000_0001, 32'd31, 1'b0);
    check("sll31_res", bus.res, 32'h8000_0000);
    do_op(3'b100, 32'hF000_0000, 32'd0, 1'b0);
    check("srl0_res", bus.res, 32'hF000_0000);
    do_op(3'b100, 32'h8000_0000, 32'd1, 1'b0);
    do_op(3'b011, 32'hDEAD_BEEF, 32'hFFFF_FFE4, 1'b0);

    // Multiply, including a result that wraps to zero
    do_op(3'b101, 32'h0001_0000, 32'h0001_0000, 1'b0);
    check("mul_wrap_zero", 32'(bus.zero), 32'd1);
    do_op(3'b101, 32'd7, 32'd6, 1'b0);
    check("mul_42", bus.res, 32'd42);

    // Inputs churning during EXEC must not disturb the latched op
    do_op(3'b101, 32'h1234_5678, 32'h9ABC_DEF1, 1'b1);
    do_op(3'b011, 32'h0000_00FF, 32'd12, 1'b1);

    // Back-to-back: start held in the done cycle
    launch(3'b001, 32'h0000_0F00, 32'h0000_00F0);
    @(posedge clk);
    finish_op(3'b001, 32'h0000_0F00, 32'h0000_00F0, 1'b0);
    launch(3'b010, 32'hFFFF_FFFF, 32'h0000_0001);
    @(posedge clk);
    finish_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);

    // Reset at cycle 10 of a MUL aborts it without a done pulse
    do_op(3'b101, 32'd3, 32'd5, 1'b0);
    @(negedge clk);
    launch(3'b101, 32'd100, 32'd200);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_res", bus.res, 32'd0);
    check("abort_zero", 32'(bus.zero), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) expect_idle("after_abort");
    do_op(3'b000, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0);

    // Reset wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1;
    launch(3'b010, 32'd1, 32'd2);
    @(posedge clk);
    #1;
    check("rst_start_busy", 32'(bus.busy), 32'd0);
    check("rst_start_res", bus.res, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    expect_idle("rst_start_dropped");

    // Random ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      do_op(rop, ra, rb, 1'(i % 3 == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
